csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit_pkg.sv | 37 +++
 rtl/csr_modify.sv | 34 +++
 rtl/csr_access_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: instruction encodings, the
// mapped CSR address set and the sequencing FSM state type.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MTIME    = 12'hB01;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MTIMECMP = 12'hB03;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic csr_is_mapped(input logic [11:0] addr);
    return addr inside {CSR_MEPC, CSR_MCYCLE, CSR_MTIME, CSR_MINSTRET,
                        CSR_MTIMECMP, CSR_MIE, CSR_MIP};
  endfunction

  // Encodings x00 are the only non-CSR forms in this opcode space.
  function automatic logic funct3_is_valid(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/csr_modify.sv
// Read-modify-write value computation for CSR instructions, including the
// no-write case for set/clear forms whose source index or zimm is zero.
module csr_modify
  import csr_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  output logic [31:0] new_value,
  output logic        write_suppress
);

  always_comb begin
    new_value      = old_value;
    write_suppress = 1'b1;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: begin
        new_value      = operand;
        write_suppress = 1'b0;
      end
      F3_CSRRS, F3_CSRRSI: begin
        new_value      = old_value | operand;
        write_suppress = (rs1 == 5'd0);
      end
      F3_CSRRC, F3_CSRRCI: begin
        new_value      = old_value & ~operand;
        write_suppress = (rs1 == 5'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction at a time: read old value, optionally write
// the modified value, then return the old value as a one-cycle response.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter bit CHECK_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rd,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_illegal
);

  state_t      state_reg;
  logic [2:0]  funct3_reg;
  logic [11:0] csr_reg;
  logic [31:0] operand_reg;
  logic [4:0]  rs1_reg;
  logic [4:0]  rd_reg;
  logic [31:0] old_reg;

  logic        req_ready_reg;
  logic [11:0] csr_addr_reg;
  logic        csr_we_reg;
  logic [31:0] csr_wdata_reg;
  logic        rsp_valid_reg;
  logic        rsp_illegal_reg;
  logic [31:0] rsp_data_reg;
  logic [4:0]  rsp_rd_reg;

  logic [31:0] req_operand;
  logic        req_illegal;
  logic [31:0] new_value;
  logic        write_suppress;

  assign req_operand = req_funct3[2] ? {27'd0, req_rs1} : req_rs1_data;
  assign req_illegal = !funct3_is_valid(req_funct3) ||
                       (CHECK_ADDR && !csr_is_mapped(req_csr));

  // Old value is taken straight from csr_rdata so the write is ready at the end of READ.
  csr_modify u_modify (
    .funct3         (funct3_reg),
    .rs1            (rs1_reg),
    .old_value      (csr_rdata),
    .operand        (operand_reg),
    .new_value      (new_value),
    .write_suppress (write_suppress)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      funct3_reg      <= '0;
      csr_reg         <= '0;
      operand_reg     <= '0;
      rs1_reg         <= '0;
      rd_reg          <= '0;
      old_reg         <= '0;
      req_ready_reg   <= 1'b1;
      csr_addr_reg    <= '0;
      csr_we_reg      <= 1'b0;
      csr_wdata_reg   <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_illegal_reg <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_rd_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_reg    <= req_funct3;
            csr_reg       <= req_csr;
            operand_reg   <= req_operand;
            rs1_reg       <= req_rs1;
            rd_reg        <= req_rd;
            req_ready_reg <= 1'b0;
            if (req_illegal) begin
              state_reg       <= ST_RESP;
              rsp_valid_reg   <= 1'b1;
              rsp_illegal_reg <= 1'b1;
              rsp_data_reg    <= '0;
              rsp_rd_reg      <= req_rd;
            end else begin
              state_reg    <= ST_READ;
              csr_addr_reg <= req_csr;
            end
          end
        end
        ST_READ: begin
          old_reg       <= csr_rdata;
          csr_addr_reg  <= csr_reg;
          csr_we_reg    <= !write_suppress;
          csr_wdata_reg <= write_suppress ? 32'd0 : new_value;
          state_reg     <= ST_WRITE;
        end
        ST_WRITE: begin
          csr_addr_reg    <= '0;
          csr_we_reg      <= 1'b0;
          csr_wdata_reg   <= '0;
          rsp_valid_reg   <= 1'b1;
          rsp_illegal_reg <= 1'b0;
          rsp_data_reg    <= old_reg;
          rsp_rd_reg      <= rd_reg;
          state_reg       <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_reg   <= 1'b0;
          rsp_illegal_reg <= 1'b0;
          rsp_data_reg    <= '0;
          rsp_rd_reg      <= '0;
          req_ready_reg   <= 1'b1;
          state_reg       <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_reg;
  assign csr_addr    = csr_addr_reg;
  assign csr_we      = csr_we_reg;
  assign csr_wdata   = csr_wdata_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_illegal = rsp_illegal_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_rd      = rsp_rd_reg;

endmodule
